// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, reset address and buffer entry layout for the npc instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int              XLEN             = 64;
    localparam int              INST_LEN         = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_buf.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it and overrides a same-cycle push.
module ifu_buf #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (cnt == (AW+1)'(DEPTH));
        empty   = (cnt == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        count   = cnt;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues one-outstanding word fetches and
// buffers returned {pc, instr} pairs for ID; an EX redirect flushes and restarts at the target.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                is_jump_i,
    input  logic [XLEN-1:0]     pc_next_i,
    output logic                imem_req_o,
    output logic [XLEN-1:0]     imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INST_LEN-1:0] imem_rdata_i,
    output logic                if_valid_o,
    input  logic                id_ready_i,
    output logic [XLEN-1:0]     pc_if_o,
    output logic [INST_LEN-1:0] instr_if_o
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q;
    logic            pend_q;
    logic            discard_q;

    logic [CW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    logic            issue_ok;
    logic            grant;
    logic            resp;
    logic            push;
    logic            pop;

    always_comb begin
        // Reserve a slot for the outstanding fetch so its response always has room.
        issue_ok    = !pend_q && !is_jump_i && !buf_full &&
                      ((buf_count + CW'(pend_q)) < CW'(BUF_DEPTH));
        imem_req_o  = rst_n && issue_ok;
        imem_addr_o = pc_q;
        grant       = imem_req_o && imem_gnt_i;
        resp        = rst_n && imem_rvalid_i && pend_q;
        push        = resp && !discard_q && !is_jump_i;
        push_entry  = '{pc: pend_pc_q, instr: imem_rdata_i};
        if_valid_o  = rst_n && !buf_empty && !is_jump_i;
        pop         = if_valid_o && id_ready_i;
        pc_if_o     = rst_n ? head.pc    : '0;
        instr_if_o  = rst_n ? head.instr : '0;
    end

    ifu_buf #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (is_jump_i),
        .push_data (push_entry),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pend_q    <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            if (grant) begin
                pend_q    <= 1'b1;
                pend_pc_q <= pc_q;
                pc_q      <= pc_q + XLEN'(4);
            end
            if (resp) begin
                pend_q    <= 1'b0;
                discard_q <= 1'b0;
            end
            // A fetch still in flight at redirect belongs to the old stream; drop it on return.
            if (is_jump_i) begin
                pc_q <= word_align(pc_next_i);
                if (pend_q && !imem_rvalid_i) discard_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory model with programmable latency plus an
// in-order fetch-stream model checked every cycle, and literal checks on key scenarios.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n, is_jump_i, imem_req_o, imem_gnt_i, imem_rvalid_i, if_valid_o, id_ready_i;
    logic [63:0] pc_next_i, imem_addr_o, pc_if_o;
    logic [31:0] imem_rdata_i, instr_if_o;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .is_jump_i     (is_jump_i),
        .pc_next_i     (pc_next_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .id_ready_i    (id_ready_i),
        .pc_if_o       (pc_if_o),
        .instr_if_o    (instr_if_o)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;
    mreq_t mq[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    logic        d_rst = 0, d_jump = 0, d_ready = 1, d_gnt = 1;
    logic [63:0] d_target = '0;

    logic [63:0] exp_pc, fetch_ptr;
    logic        s_req, s_valid, s_grant, s_deliv;
    logic [63:0] s_addr, s_pc;
    logic [63:0] last_deliv_pc;
    int          dcyc[$];
    logic [63:0] dpc[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after negedge, settle, compare against the stream model.
    task automatic tick();
        int          live;
        logic [63:0] inflight;
        live = 0;
        foreach (mq[i]) if (!mq[i].stale) live++;
        rst_n      = d_rst;
        is_jump_i  = d_jump;
        pc_next_i  = d_target;
        id_ready_i = d_ready;
        imem_gnt_i = d_gnt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = if_valid_o; s_pc = pc_if_o;
        s_grant = 1'b0; s_deliv = 1'b0;
        if (!d_rst) begin
            chk("reset_req", imem_req_o, 0);
            chk("reset_valid", if_valid_o, 0);
            chk("reset_pc_if", pc_if_o, 0);
            chk("reset_instr_if", instr_if_o, 0);
            exp_pc = RST_PC; fetch_ptr = RST_PC;
            foreach (mq[i]) mq[i].stale = 1'b1;
        end else if (d_jump) begin
            chk("jump_req", imem_req_o, 0);
            chk("jump_valid", if_valid_o, 0);
            exp_pc    = {d_target[63:2], 2'b00};
            fetch_ptr = exp_pc;
        end else begin
            inflight = (fetch_ptr - exp_pc) >> 2;
            if (if_valid_o) begin
                chk("stream_pc", pc_if_o, exp_pc);
                chk("stream_instr", instr_if_o, mem_word(exp_pc));
                if (d_ready) begin
                    s_deliv = 1'b1; last_deliv_pc = exp_pc;
                    dcyc.push_back(cyc); dpc.push_back(exp_pc);
                    exp_pc += 64'd4;
                end
            end
            if (imem_req_o) begin
                chk("req_addr", imem_addr_o, fetch_ptr);
                chk("req_one_outstanding", live, 0);
                chk("req_space", inflight < DEPTH, 1);
                if (d_gnt) begin
                    mq.push_back('{addr: imem_addr_o, due: cyc + lat, stale: 1'b0});
                    fetch_ptr += 64'd4;
                    s_grant = 1'b1;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        d_rst = 0; d_jump = 0;
        ticks(2);
        d_rst = 1;
    endtask

    task automatic wait_grant(input logic [63:0] a, input string nm);
        int b = 0;
        do begin tick(); b++; end while (!(s_grant && s_addr == a) && b < 60);
        chk(nm, s_grant && s_addr == a, 1);
    endtask

    task automatic wait_req(input string nm);
        int b = 0;
        do begin tick(); b++; end while (!s_req && b < 60);
        chk(nm, s_req, 1);
    endtask

    task automatic wait_deliv(input string nm);
        int b = 0;
        do begin tick(); b++; end while (!s_deliv && b < 60);
        chk(nm, s_deliv, 1);
    endtask

    initial begin
        int rel, jc;
        rst_n = 0; is_jump_i = 0; pc_next_i = '0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = '0; id_ready_i = 0;
        exp_pc = RST_PC; fetch_ptr = RST_PC; last_deliv_pc = '0;
        @(negedge clk);
        ticks(3);

        // 1: streaming at the 2-cycle cadence from RESET_PC
        d_rst = 1; lat = 1; d_ready = 1;
        rel = cyc; dcyc.delete(); dpc.delete();
        tick();
        chk("t1_first_req", s_req, 1);
        chk("t1_first_addr", s_addr, 64'h8000_0000);
        ticks(10);
        chk("t1_deliv_count", dcyc.size(), 5);
        if (dcyc.size() == 5) begin
            chk("t1_first_latency", dcyc[0] - rel, 2);
            for (int k = 1; k < 5; k++) chk("t1_cadence", dcyc[k] - dcyc[k-1], 2);
            chk("t1_pc0", dpc[0], 64'h8000_0000);
            chk("t1_pc1", dpc[1], 64'h8000_0004);
            chk("t1_pc4", dpc[4], 64'h8000_0010);
        end

        // 2: ID stalls for 10 cycles, buffer fills, then drains in order
        d_ready = 0;
        ticks(10);
        chk("t2_full_req", s_req, 0);
        chk("t2_full_valid", s_valid, 1);
        chk("t2_head_pc", s_pc, 64'h8000_0014);
        d_ready = 1; dcyc.delete(); dpc.delete();
        ticks(6);
        chk("t2_drain_count", dpc.size(), 4);
        if (dpc.size() == 4) begin
            chk("t2_drain_pc0", dpc[0], 64'h8000_0014);
            chk("t2_drain_pc1", dpc[1], 64'h8000_0018);
            chk("t2_drain_pc2", dpc[2], 64'h8000_001C);
        end

        // 3: redirect while the fetch of 0x80000008 is in flight (3-cycle memory)
        do_reset(); lat = 3;
        wait_grant(64'h8000_0008, "t3_grant_8");
        d_jump = 1; d_target = 64'h8000_1000; jc = cyc;
        tick();
        d_jump = 0;
        wait_req("t3_req_target");
        chk("t3_target_addr", s_addr, 64'h8000_1000);
        chk("t3_req_after_discard", cyc - 1 - jc, 3);
        wait_deliv("t3_deliv");
        chk("t3_first_pc", last_deliv_pc, 64'h8000_1000);

        // 4a: redirect in the same cycle as an rvalid that would fill the buffer
        do_reset(); lat = 2; d_ready = 0;
        wait_grant(64'h8000_0004, "t4_grant_4");
        tick();
        d_jump = 1; d_target = 64'h8000_4000;
        tick();
        d_jump = 0;
        tick();
        chk("t4a_req_n1", s_req, 1);
        chk("t4a_addr_n1", s_addr, 64'h8000_4000);
        chk("t4a_valid_n1", s_valid, 0);
        // 4b: redirect with a full buffer
        ticks(8);
        chk("t4b_full_req", s_req, 0);
        chk("t4b_full_valid", s_valid, 1);
        d_jump = 1; d_target = 64'h8000_5000;
        tick();
        d_jump = 0;
        tick();
        chk("t4b_req_n1", s_req, 1);
        chk("t4b_addr_n1", s_addr, 64'h8000_5000);
        chk("t4b_valid_n1", s_valid, 0);
        d_ready = 1;
        wait_deliv("t4b_deliv");
        chk("t4b_first_pc", last_deliv_pc, 64'h8000_5000);

        // 5: misaligned target, then back-to-back redirects with a fetch in flight
        do_reset(); lat = 1;
        wait_grant(64'h8000_0000, "t5_grant_0");
        lat = 3;
        d_jump = 1; d_target = 64'h8000_2002;
        tick();
        d_jump = 0;
        tick();
        chk("t5_aligned_req", s_req, 1);
        chk("t5_aligned_addr", s_addr, 64'h8000_2000);
        d_jump = 1; d_target = 64'h8000_2002;
        tick();
        d_target = 64'h8000_3000;
        tick();
        d_jump = 0;
        wait_req("t5_req_second");
        chk("t5_second_addr", s_addr, 64'h8000_3000);
        wait_deliv("t5_deliv");
        chk("t5_first_pc", last_deliv_pc, 64'h8000_3000);

        // 6: reset mid-stream with a request outstanding; stale rvalid after release
        do_reset(); lat = 3;
        wait_grant(64'h8000_0000, "t6_grant_0");
        d_rst = 0;
        tick();
        chk("t6_rst_req", s_req, 0);
        chk("t6_rst_valid", s_valid, 0);
        tick();
        d_rst = 1;
        tick();
        chk("t6_restart_req", s_req, 1);
        chk("t6_restart_addr", s_addr, RST_PC);
        wait_deliv("t6_deliv0");
        chk("t6_pc0", last_deliv_pc, 64'h8000_0000);
        wait_deliv("t6_deliv1");
        chk("t6_pc1", last_deliv_pc, 64'h8000_0004);

        ticks(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
